wb_unit: RTL

- Writeback stage for the RV32I core. Sole writer into the 32x32 register file.
- Accepts results from two producers through valid/ready handshakes: the ALU path and the load (LSU) path. Arbitrates between them, and sign- or zero-extends load data by funct3 and byte offset.
- Drives the register-file write port through one registered stage.
- Keeps a per-register pending scoreboard, which issue logic uses for RAW hazard stalls, plus a forwarding tap.

---
 rtl/wb_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// wb_unit: RV32I writeback stage. It arbitrates ALU/LSU results (LSU first), extends
// load data, drives the register-file write port and tracks pending destinations.
module wb_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [AW-1:0]   i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [AW-1:0]   i_lsu_rd,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [1:0]      i_lsu_addr_lo,
  input  logic [XLEN-1:0] i_lsu_rdata,
  input  logic            i_wb_stall,
  input  logic            i_issue_en,
  input  logic [AW-1:0]   i_issue_rd,
  output logic            o_write_en,
  output logic [AW-1:0]   o_write_addr,
  output logic [XLEN-1:0] o_data_in,
  output logic [NREG-1:0] o_pending,
  output logic            o_fwd_valid,
  output logic [AW-1:0]   o_fwd_rd,
  output logic [XLEN-1:0] o_fwd_data,
  output logic            o_load_err
);

  // Returns {error, extended value} for one load beat.
  function automatic logic [XLEN:0] f_load_ext(input logic [2:0]      funct3,
                                               input logic [1:0]      addr_lo,
                                               input logic [XLEN-1:0] rdata);
    logic [7:0]      b;
    logic [15:0]     h;
    logic            err;
    logic [XLEN-1:0] val;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  begin err = 1'b0;                val = {{(XLEN-8){b[7]}}, b};   end
      3'b001:  begin err = addr_lo[0];          val = {{(XLEN-16){h[15]}}, h}; end
      3'b010:  begin err = (addr_lo != 2'd0);   val = rdata;                   end
      3'b100:  begin err = 1'b0;                val = {{(XLEN-8){1'b0}}, b};   end
      3'b101:  begin err = addr_lo[0];          val = {{(XLEN-16){1'b0}}, h};  end
      default: begin err = 1'b1;                val = {XLEN{1'b0}};            end
    endcase
    return {err, val};
  endfunction

  logic            w_alu_ready, w_lsu_ready, w_alu_acc, w_lsu_acc, w_acc;
  logic            w_err, w_wr;
  logic [AW-1:0]   w_rd;
  logic [XLEN:0]   w_ext;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] w_pending_nxt;

  logic            r_write_en;
  logic [AW-1:0]   r_write_addr;
  logic [XLEN-1:0] r_data_in;
  logic [NREG-1:0] r_pending;
  logic            r_load_err;

  assign w_alu_ready = !rst && !i_wb_stall && !i_lsu_valid;
  assign w_lsu_ready = !rst && !i_wb_stall;
  assign w_lsu_acc   = i_lsu_valid && w_lsu_ready;
  assign w_alu_acc   = i_alu_valid && w_alu_ready;
  assign w_acc       = w_lsu_acc || w_alu_acc;
  assign w_rd        = w_lsu_acc ? i_lsu_rd : i_alu_rd;
  assign w_ext       = f_load_ext(i_lsu_funct3, i_lsu_addr_lo, i_lsu_rdata);
  assign w_err       = w_lsu_acc && w_ext[XLEN];
  assign w_data      = w_lsu_acc ? w_ext[XLEN-1:0] : i_alu_data;
  // Faulting loads and x0 destinations retire without touching the register file.
  assign w_wr        = w_acc && !w_err && (w_rd != {AW{1'b0}});

  // Scoreboard next state: issue sets, retirement clears, set wins; x0 never pends.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 1; i < NREG; i++) begin
      w_pending_nxt[i] = (i_issue_en && (i_issue_rd == AW'(i))) ? 1'b1 :
                         (w_acc && (w_rd == AW'(i)))            ? 1'b0 : r_pending[i];
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Write port register stage; address/data keep the last written value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_en   <= 1'b0;
      r_write_addr <= {AW{1'b0}};
      r_data_in    <= {XLEN{1'b0}};
      r_load_err   <= 1'b0;
      r_pending    <= {NREG{1'b0}};
    end else begin
      r_write_en <= w_wr;
      r_load_err <= w_err;
      r_pending  <= w_pending_nxt;
      if (w_wr) begin
        r_write_addr <= w_rd;
        r_data_in    <= w_data;
      end
    end
  end

  assign o_alu_ready  = w_alu_ready;
  assign o_lsu_ready  = w_lsu_ready;
  assign o_write_en   = r_write_en;
  assign o_write_addr = r_write_addr;
  assign o_data_in    = r_data_in;
  assign o_pending    = r_pending;
  assign o_load_err   = r_load_err;
  assign o_fwd_valid  = r_write_en;
  assign o_fwd_rd     = r_write_addr;
  assign o_fwd_data   = r_data_in;

endmodule
